// File: rtl/booth_r4_multiplier.sv
// rtl/booth_r4_multiplier.sv - sequential radix-4 Booth multiplier, signed/unsigned, N/2+1 steps
// Optional accumulate-on-completion with acc_clr when BOOTH_ACC_EN is defined.
module booth_r4_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode_signed,
`ifdef BOOTH_ACC_EN
  input  logic           acc_clr,
`endif
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] data_out,
  output logic           done,
  output logic           busy
);

  localparam int STEPS = N / 2 + 1;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int W     = 2 * N + 2;

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   acc_q;
  logic [N+1:0]   mplier_q;
  logic           prev_q;
  logic [CW-1:0]  cnt_q;
`ifdef BOOTH_ACC_EN
  logic           acc_clr_q;
`endif

  logic [2:0]     trip;
  logic [W-1:0]   term;
  logic [W-1:0]   acc_next;

  // mcand_q is pre-shifted by 4^i, so the triplet always sits in mplier_q[1:0] plus prev_q
  always_comb begin
    trip = {mplier_q[1:0], prev_q};
    term = '0;
    case (trip)
      3'b001, 3'b010: term = mcand_q;
      3'b011:         term = mcand_q << 1;
      3'b100:         term = -(mcand_q << 1);
      3'b101, 3'b110: term = -mcand_q;
      default:        term = '0;
    endcase
    acc_next = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef BOOTH_ACC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_q  <= mode_signed ? {{(N+2){a[N-1]}}, a} : {{(N+2){1'b0}}, a};
            mplier_q <= mode_signed ? {{2{b[N-1]}}, b} : {2'b00, b};
            prev_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state    <= CALC;
`ifdef BOOTH_ACC_EN
            acc_clr_q <= acc_clr;
`endif
          end
        end
        CALC: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
          prev_q   <= mplier_q[1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
`ifdef BOOTH_ACC_EN
            data_out <= (acc_clr_q ? '0 : data_out) + acc_next[2*N-1:0];
`else
            data_out <= acc_next[2*N-1:0];
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// tb/tb_booth_r4_multiplier.sv - directed bench for booth_r4_multiplier at N=4
module tb_booth_r4_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           mode_signed;
  logic           acc_clr;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] data_out;
  logic           done;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 clk = ~clk;

  booth_r4_multiplier #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode_signed (mode_signed),
`ifdef BOOTH_ACC_EN
    .acc_clr     (acc_clr),
`endif
    .a           (a),
    .b           (b),
    .data_out    (data_out),
    .done        (done),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start sampled at edge k, done expected exactly at edge k+3
  task automatic run_op(input string tag, input logic sgn, input logic [N-1:0] av,
                        input logic [N-1:0] bv, input logic [2*N-1:0] exp);
    a = av; b = bv; mode_signed = sgn; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_k"}, 16'(busy), 16'd1);
    check({tag, "_done_k"}, 16'(done), 16'd0);
    tick();
    tick();
    check({tag, "_busy_k2"}, 16'(busy), 16'd1);
    check({tag, "_done_k2"}, 16'(done), 16'd0);
    tick();
    check({tag, "_done_k3"}, 16'(done), 16'd1);
    check({tag, "_busy_k3"}, 16'(busy), 16'd0);
    check({tag, "_data"}, 16'(data_out), 16'(exp));
    tick();
    check({tag, "_done_k4"}, 16'(done), 16'd0);
    check({tag, "_hold"}, 16'(data_out), 16'(exp));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_signed = 1'b0; acc_clr = 1'b1; a = '0; b = '0;
    #22;
    check("rst_data", 16'(data_out), 16'h00);
    check("rst_done", 16'(done), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    tick();

    run_op("s_m7x3", 1'b1, 4'b1001, 4'b0011, 8'hEB);
    run_op("u_15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
    run_op("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
    run_op("s_m8x7", 1'b1, 4'h8, 4'h7, 8'hC8);
    run_op("s_m1xm1", 1'b1, 4'hF, 4'hF, 8'h01);
    run_op("u_9x3", 1'b0, 4'h9, 4'h3, 8'h1B);
    run_op("s_7x7", 1'b1, 4'h7, 4'h7, 8'h31);
    run_op("u_0x13", 1'b0, 4'h0, 4'hD, 8'h00);

    // start re-pulsed mid-CALC with new operands must be ignored
    a = 4'h3; b = 4'h5; mode_signed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'h2; b = 4'h2; mode_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) begin
        pulses++;
        check("mid_data", 16'(data_out), 16'h0F);
      end
      tick();
    end
    check("mid_pulses", 16'(pulses), 16'd1);

    // reset during CALC aborts without a done pulse
    a = 4'h5; b = 4'h3; mode_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 16'(data_out), 16'h00);
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_done", 16'(done), 16'd0);
    tick();
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) pulses++;
    end
    check("arst_pulses", 16'(pulses), 16'd0);
    run_op("post_rst", 1'b0, 4'h5, 4'h3, 8'h0F);

    // back-to-back: start held high through the done cycle
    a = 4'b1001; b = 4'b0011; mode_signed = 1'b1; start = 1'b1;
    tick();
    a = 4'h6; b = 4'h7; mode_signed = 1'b0;
    tick();
    tick();
    tick();
    check("b2b_done1", 16'(done), 16'd1);
    check("b2b_data1", 16'(data_out), 16'hEB);
    tick();
    start = 1'b0;
    check("b2b_busy2", 16'(busy), 16'd1);
    check("b2b_done_off", 16'(done), 16'd0);
    tick();
    tick();
    tick();
    check("b2b_done2", 16'(done), 16'd1);
    check("b2b_data2", 16'(data_out), 16'h2A);
    tick();

`ifdef BOOTH_ACC_EN
    acc_clr = 1'b1;
    run_op("acc_3x4", 1'b0, 4'h3, 4'h4, 8'd12);
    acc_clr = 1'b0;
    run_op("acc_2x5", 1'b0, 4'h2, 4'h5, 8'd22);
    acc_clr = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_r4_multiplier.md
BOOTH_R4_MULTIPLIER -- requirements
Module: booth_r4_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, giving operand width; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port mode_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, N bits: multiplicand.
REQ-007 SHALL have port b, input, N bits: multiplier.
REQ-008 SHALL have port data_out, output, 2N bits: registered product.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking data_out valid.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.

Function
REQ-011 SHALL implement FSM states IDLE and CALC only.
REQ-012 IDLE: start=1 at a rising edge SHALL register a, b and mode_signed, clear the partial product, set step count to 0 and enter CALC.
REQ-013 SHALL extend the registered multiplier to N+2 bits before recoding: sign-extend when mode_signed=1, zero-extend when mode_signed=0.
REQ-014 SHALL extend the multiplicand to 2N+2 bits the same way.
REQ-015 CALC: each edge SHALL perform one radix-4 Booth step, selecting 0, +-M or +-2M from bit triplet (b[2i+1], b[2i], b[2i-1]) with b[-1]=0, weighted by 4^i.
REQ-016 SHALL run exactly N/2+1 steps per operation in both modes; latency is fixed.
REQ-017 On the edge that performs the last step, SHALL write the low 2N bits of the result to data_out, drive done=1 for exactly one cycle, and return to IDLE.
REQ-018 With start sampled at edge k, done SHALL be high from edge k+N/2+1 to edge k+N/2+2.
REQ-019 busy SHALL be 1 from edge k until the edge on which done rises.
REQ-020 SHALL ignore start and any change on a, b or mode_signed while busy=1.
REQ-021 SHALL hold data_out stable between done pulses.
REQ-022 SHALL accept start on the cycle in which done=1, since the FSM is then in IDLE, giving back-to-back operations with no gap cycle.
REQ-023 SHALL produce exact results for the extremes: signed -2^(N-1) x -2^(N-1) = +2^(2N-2), and unsigned (2^N-1)^2; no overflow is possible.

Reset
REQ-024 rst_n=0 SHALL, asynchronously, force state IDLE, data_out=0, done=0, busy=0 and clear all internal registers.
REQ-025 Reset during CALC SHALL abort the operation without a done pulse.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL begin a normal operation.

Configuration
REQ-027 With macro BOOTH_ACC_EN defined, SHALL add input port acc_clr (1 bit).
REQ-028 With BOOTH_ACC_EN defined, on completion SHALL set data_out to the previous data_out plus the product, truncated modulo 2^(2N).
REQ-029 With BOOTH_ACC_EN defined, if acc_clr=1 is sampled with start, SHALL use 0 as the previous value for that operation.
REQ-030 With BOOTH_ACC_EN undefined, the acc_clr port SHALL be absent and data_out SHALL equal the product alone.

Verification
REQ-031 N=4, signed: a=4'b1001 (-7), b=4'b0011 (3), start pulse -> data_out=8'hEB (-21), done high 3 cycles after the start edge, busy high for 3 cycles.
REQ-032 N=4, unsigned: a=15, b=15 -> data_out=225; signed: a=-8, b=-8 -> data_out=64; signed: a=-8, b=7 -> data_out=-56.
REQ-033 start pulsed again mid-CALC with different operands -> first result unaffected, exactly one done pulse.
REQ-034 rst_n pulsed low during CALC -> outputs 0 immediately, no done pulse; a new start then completes correctly.
REQ-035 Back-to-back: start held high across the done cycle -> second result follows with no idle gap.
REQ-036 With BOOTH_ACC_EN: 3x4 with acc_clr=1, then 2x5 with acc_clr=0 -> data_out=12, then 22.
